// File: rtl/counter_seq_pkg.sv
// counter_seq_ctrl shared types: FSM encoding and job mode constants.
// TURN only exists when COUNTER_SEQ_BOUNCE_EN is defined.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
`ifdef COUNTER_SEQ_BOUNCE_EN
    S_TURN,
`endif
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/counter_seq_ctrl_clk_en_gen.sv
// Prescaler: ticks once every presc+1 cycles, restarting from 0 on clear.
// The tick lands on the last count of each period.
module clk_en_gen #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = (cnt == presc);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Job sequencer driving the control side of an up/down counter.
// Define COUNTER_SEQ_BOUNCE_EN to add bounce mode and the TURN state.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int N       = 2,
  parameter int PRESC_W = 4,
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N-1:0]       cmd_start,
  input  logic [N-1:0]       cmd_bound,
  input  logic [1:0]         cmd_mode,
  input  logic [PRESC_W-1:0] cmd_presc,
  input  logic [REP_W-1:0]   cmd_reps,
  input  logic               abort,
  input  logic               co,
  output logic               load,
  output logic               en,
  output logic               clkEN,
  output logic               direction,
  output logic [N-1:0]       par_load,
  output logic [N-1:0]       upper_bound,
  output logic               busy,
  output logic               done
);

  state_t state, state_d;

  logic [N-1:0]       start_q;
  logic [PRESC_W-1:0] presc_q;
  logic [REP_W-1:0]   reps_q;
  logic [REP_W-1:0]   rep_cnt;
  logic [REP_W-1:0]   rep_nxt;
  logic               accept;
  logic               last;
  logic               tick;
  logic               turn_hit;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_ready && cmd_valid && !abort;
  assign par_load  = start_q;
  assign rep_nxt   = rep_cnt + {{(REP_W-1){1'b0}}, 1'b1};
  assign last      = (reps_q != '0) && (rep_nxt == reps_q);

`ifdef COUNTER_SEQ_BOUNCE_EN
  logic [N-1:0] bound_q;
  logic [1:0]   mode_q;
  logic         phase;
  logic         bounce;

  assign bounce   = (mode_q == MODE_BOUNCE);
  assign turn_hit = bounce && !phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      bound_q <= '0;
      mode_q  <= '0;
      phase   <= 1'b0;
    end else if (accept) begin
      bound_q <= cmd_bound;
      mode_q  <= cmd_mode;
      phase   <= 1'b0;
    end else if (state == S_TURN && !abort) begin
      phase <= !phase;
    end
  end
`else
  assign turn_hit = 1'b0;
`endif

  clk_en_gen #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clear(state != S_RUN),
    .presc(presc_q),
    .tick (tick)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    en      = 1'b0;
    clkEN   = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        clkEN   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        en    = !co;
        clkEN = tick;
        if (co) begin
          if (last && !turn_hit) state_d = S_DONE;
`ifdef COUNTER_SEQ_BOUNCE_EN
          else if (bounce) state_d = S_TURN;
`endif
          else state_d = S_LOAD;
        end
      end
`ifdef COUNTER_SEQ_BOUNCE_EN
      S_TURN: begin
        state_d = S_RUN;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over any hit or completion in the same cycle
    if (abort && state != S_IDLE) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      start_q     <= '0;
      presc_q     <= '0;
      reps_q      <= '0;
      rep_cnt     <= '0;
      direction   <= 1'b0;
      upper_bound <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        start_q     <= cmd_start;
        presc_q     <= cmd_presc;
        reps_q      <= cmd_reps;
        rep_cnt     <= '0;
        direction   <= (cmd_mode != MODE_DOWN);
        upper_bound <= cmd_bound;
      end
      if (state == S_RUN && co && !abort && !turn_hit) begin
        rep_cnt <= rep_nxt;
      end
`ifdef COUNTER_SEQ_BOUNCE_EN
      if (state == S_TURN && !abort) begin
        direction   <= !direction;
        upper_bound <= phase ? bound_q : start_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl driving a 4-bit up/down counter model.
// Bounce expectations follow COUNTER_SEQ_BOUNCE_EN.
module tb_counter_seq_ctrl;

  localparam int N  = 4;
  localparam int PW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_start;
  logic [N-1:0]  cmd_bound;
  logic [1:0]    cmd_mode;
  logic [PW-1:0] cmd_presc;
  logic [RW-1:0] cmd_reps;
  logic          abort;
  logic          co;
  logic          load;
  logic          en;
  logic          clkEN;
  logic          direction;
  logic [N-1:0]  par_load;
  logic [N-1:0]  upper_bound;
  logic          busy;
  logic          done;
  logic [N-1:0]  w;

  always #5 clk = ~clk;

  counter_seq_ctrl #(
    .N(N), .PRESC_W(PW), .REP_W(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_bound(cmd_bound),
    .cmd_mode(cmd_mode), .cmd_presc(cmd_presc),
    .cmd_reps(cmd_reps), .abort(abort), .co(co),
    .load(load), .en(en), .clkEN(clkEN),
    .direction(direction), .par_load(par_load),
    .upper_bound(upper_bound), .busy(busy), .done(done)
  );

  always_ff @(posedge clk) begin
    if (reset) w <= '0;
    else if (clkEN) begin
      if (load) w <= par_load;
      else if (en) w <= direction ? w + 1'b1 : w - 1'b1;
    end
  end

  assign co = (w == upper_bound);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int r_done_cyc, r_ndone, r_nload, r_ntog, r_nclk;
  int r_co_cyc, r_seqn, r_ready, r_w8, r_w_ab, r_ab_busy, r_ab_en;
  logic [31:0] r_seq;

  task automatic run(input int st, input int bd, input int md,
                     input int pr, input int rp, input int abort_at,
                     input int budget);
    int  i;
    int  last;
    bit  fin;
    logic dir_prev;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_start = N'(st);
    cmd_bound = N'(bd);
    cmd_mode  = 2'(md);
    cmd_presc = PW'(pr);
    cmd_reps  = RW'(rp);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    r_done_cyc = -1; r_ndone = 0; r_nload = 0; r_ntog = 0;
    r_nclk = 0; r_co_cyc = -1; r_seqn = 0; r_seq = '0;
    r_ready = -1; r_w8 = -1; r_w_ab = -1; r_ab_busy = -1; r_ab_en = -1;
    last = -1; fin = 0; i = 1; dir_prev = direction;
    while (!fin && i <= budget) begin
      if (load) r_nload++;
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = i;
      end
      if (direction != dir_prev) r_ntog++;
      dir_prev = direction;
      if (i >= 2 && int'(w) != last) begin
        last  = int'(w);
        r_seq = {r_seq[27:0], w};
        r_seqn++;
      end
      if (clkEN && !load && r_co_cyc < 0) r_nclk++;
      if (i >= 2 && co && r_co_cyc < 0) r_co_cyc = i;
      if (i == 8) r_w8 = int'(w);
      if (r_done_cyc >= 0 && i == r_done_cyc + 1) begin
        r_ready = cmd_ready;
        fin = 1;
      end
      if (abort_at > 0 && i == abort_at + 1) begin
        r_ab_busy = busy;
        r_ab_en   = en;
        r_ready   = cmd_ready;
        abort     = 1'b0;
        fin       = 1;
      end
      if (abort_at > 0 && i == abort_at) begin
        r_w_ab = int'(w);
        abort  = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        i++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_bound = '0; cmd_mode = '0;
    cmd_presc = '0; cmd_reps = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", load, 0);
    chk("rst_en", en, 0);
    chk("rst_clken", clkEN, 0);
    chk("rst_dir", direction, 0);
    chk("rst_ub", upper_bound, 0);
    chk("rst_pl", par_load, 0);
    reset = 1'b0;

    @(negedge clk);
    cmd_start = 4'd2; cmd_bound = 4'd5; cmd_reps = 4'd1;
    cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_block", busy, 0);
    cmd_valid = 1'b0; abort = 1'b0;

    run(2, 5, 0, 0, 1, 0, 40);
    chk("up_done_cyc", r_done_cyc, 6);
    chk("up_seq", r_seq, 32'h0000_2345);
    chk("up_ndone", r_ndone, 1);
    chk("up_nload", r_nload, 1);
    chk("up_ready_after", r_ready, 1);

    run(1, 14, 1, 0, 2, 0, 40);
    chk("dn_done_cyc", r_done_cyc, 11);
    chk("dn_seq", r_seq, 32'h10FE_10FE);
    chk("dn_seqn", r_seqn, 8);
    chk("dn_nload", r_nload, 2);
    chk("dn_ndone", r_ndone, 1);

    run(0, 3, 0, 2, 1, 0, 60);
    chk("pr_co_cyc", r_co_cyc, 11);
    chk("pr_ticks", r_nclk, 3);
    chk("pr_w8", r_w8, 2);
    chk("pr_done_cyc", r_done_cyc, 12);

    run(3, 6, 2, 0, 2, 0, 60);
`ifdef COUNTER_SEQ_BOUNCE_EN
    chk("bn_done_cyc", r_done_cyc, 21);
    chk("bn_dir_tog", r_ntog, 3);
    chk("bn_seq", r_seq, 32'h4345_6543);
    chk("bn_seqn", r_seqn, 13);
    chk("bn_nload", r_nload, 1);
`else
    chk("bn_done_cyc", r_done_cyc, 11);
    chk("bn_dir_tog", r_ntog, 0);
    chk("bn_seq", r_seq, 32'h3456_3456);
    chk("bn_nload", r_nload, 2);
`endif
    chk("bn_ndone", r_ndone, 1);

    run(2, 9, 0, 0, 0, 4, 40);
    chk("ab_w", r_w_ab, 4);
    chk("ab_busy", r_ab_busy, 0);
    chk("ab_en", r_ab_en, 0);
    chk("ab_ready", r_ready, 1);
    chk("ab_ndone", r_ndone, 0);

    run(7, 7, 0, 0, 3, 0, 40);
    chk("eq_done_cyc", r_done_cyc, 7);
    chk("eq_nload", r_nload, 3);
    chk("eq_ndone", r_ndone, 1);
    chk("eq_seq", r_seq, 32'h0000_0007);

    @(negedge clk);
    cmd_start = 4'd0; cmd_bound = 4'd9; cmd_mode = 2'd0;
    cmd_presc = 4'd0; cmd_reps = 4'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ub", upper_bound, 0);
    @(negedge clk);
    chk("mid_rst_done2", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
